// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO, operand staging and response capture around a combinational ALU
// Optional per-command tag passthrough is enabled by defining ALU_ISSUE_TAG_EN.
module alu_issue_stage #(
  parameter int W        = 64,
  parameter int DEPTH    = 4,
  parameter int MUL_WAIT = 2
`ifdef ALU_ISSUE_TAG_EN
  , parameter int TAG_W  = 4
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef ALU_ISSUE_TAG_EN
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic [TAG_W-1:0]         rsp_tag,
`endif
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_opcode,
  input  logic [W-1:0]             cmd_a,
  input  logic [W-1:0]             cmd_b,
  input  logic [4:0]               cmd_shamt,
  output logic [3:0]               alu_opcode,
  output logic [W-1:0]             alu_input1,
  output logic [W-1:0]             alu_input2,
  output logic [4:0]               alu_shiftValue,
  input  logic [W-1:0]             alu_result,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [W-1:0]             rsp_result,
  output logic                     rsp_carry,
  output logic [3:0]               rsp_opcode,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = (MUL_WAIT > 0) ? $clog2(MUL_WAIT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [3:0] OP_MUL = 4'd7;

  logic [3:0]   op_mem [DEPTH];
  logic [W-1:0] a_mem  [DEPTH];
  logic [W-1:0] b_mem  [DEPTH];
  logic [4:0]   sh_mem [DEPTH];
`ifdef ALU_ISSUE_TAG_EN
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [TAG_W-1:0] cur_tag;
`endif

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [1:0]     state;
  logic [WCW-1:0] wcnt;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign cmd_ready  = !full;
  assign fifo_count = count;
  // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
  assign push       = cmd_valid && !full;
  assign pop        = !empty && ((state == S_IDLE) || ((state == S_HOLD) && rsp_ready));

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr] <= cmd_opcode;
      a_mem[wr_ptr]  <= cmd_a;
      b_mem[wr_ptr]  <= cmd_b;
      sh_mem[wr_ptr] <= cmd_shamt;
`ifdef ALU_ISSUE_TAG_EN
      tag_mem[wr_ptr] <= cmd_tag;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wcnt           <= '0;
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_carry      <= 1'b0;
      rsp_opcode     <= '0;
`ifdef ALU_ISSUE_TAG_EN
      cur_tag        <= '0;
      rsp_tag        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) state <= S_EXEC;
        end
        S_EXEC: begin
          if (wcnt == '0) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_opcode <= alu_opcode;
`ifdef ALU_ISSUE_TAG_EN
            rsp_tag    <= cur_tag;
`endif
            rsp_valid  <= 1'b1;
            state      <= S_HOLD;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= pop ? S_EXEC : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Operands are only ever loaded here, so the ALU inputs stay frozen through EXEC and HOLD.
      if (pop) begin
        alu_opcode     <= op_mem[rd_ptr];
        alu_input1     <= a_mem[rd_ptr];
        alu_input2     <= b_mem[rd_ptr];
        alu_shiftValue <= sh_mem[rd_ptr];
        wcnt           <= (op_mem[rd_ptr] == OP_MUL) ? WCW'(MUL_WAIT) : '0;
`ifdef ALU_ISSUE_TAG_EN
        cur_tag        <= tag_mem[rd_ptr];
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized and directed checks of alu_issue_stage against a response-queue model
module tb_alu_issue_stage;

  localparam int W     = 64;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_opcode;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [4:0]   cmd_shamt;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_input1;
  logic [W-1:0] alu_input2;
  logic [4:0]   alu_shiftValue;
  logic [W-1:0] alu_result;
  logic         alu_carry;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic [3:0]   rsp_opcode;
  logic [2:0]   fifo_count;
`ifdef ALU_ISSUE_TAG_EN
  logic [3:0]   cmd_tag;
  logic [3:0]   rsp_tag;
`endif

  alu_issue_stage #(.W(W), .DEPTH(DEPTH), .MUL_WAIT(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef ALU_ISSUE_TAG_EN
    .cmd_tag        (cmd_tag),
    .rsp_tag        (rsp_tag),
`endif
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opcode     (cmd_opcode),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_shamt      (cmd_shamt),
    .alu_opcode     (alu_opcode),
    .alu_input1     (alu_input1),
    .alu_input2     (alu_input2),
    .alu_shiftValue (alu_shiftValue),
    .alu_result     (alu_result),
    .alu_carry      (alu_carry),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_carry      (rsp_carry),
    .rsp_opcode     (rsp_opcode),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] alu_fn(input logic [3:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input logic [4:0] sh);
    logic [64:0] r;
    r = '0;
    case (op)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} - {1'b0, b};
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a << sh};
      4'd5:    r = {1'b0, a >> sh};
      4'd6:    r = {1'b0, 64'($signed(a) >>> sh)};
      4'd7:    r = {1'b0, a * b};
      4'd8:    r = {1'b0, ~a};
      4'd9:    r = {1'b0, ~(a | b)};
      4'd10:   r = {1'b0, a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [64:0] alu_out;
  always_comb alu_out = alu_fn(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
  assign alu_result = alu_out[63:0];
  assign alu_carry  = alu_out[64];

  typedef struct {
    logic [63:0] r;
    logic        c;
    logic [3:0]  op;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert;
  int   n_fail;
  int   n_push;
  int   n_rsp;
  bit   last_fire;
  bit   rand_ready;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: judge both handshakes before the edge, then update the model after it.
  task automatic step();
    bit          fire;
    bit          rfire;
    exp_t        cmd_e;
    exp_t        got;
    exp_t        want;
    logic [64:0] m;
    if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
    fire      = cmd_valid && cmd_ready;
    rfire     = rsp_valid && rsp_ready;
    m         = alu_fn(cmd_opcode, cmd_a, cmd_b, cmd_shamt);
    cmd_e.r   = m[63:0];
    cmd_e.c   = m[64];
    cmd_e.op  = cmd_opcode;
    cmd_e.tag = '0;
`ifdef ALU_ISSUE_TAG_EN
    cmd_e.tag = cmd_tag;
`endif
    got.r   = rsp_result;
    got.c   = rsp_carry;
    got.op  = rsp_opcode;
    got.tag = '0;
`ifdef ALU_ISSUE_TAG_EN
    got.tag = rsp_tag;
`endif
    @(posedge clk);
    #1;
    last_fire = fire && rst_n;
    if (rst_n) begin
      if (rfire) begin
        n_rsp++;
        n_assert++;
        assert (exp_q.size() != 0)
        else begin
          n_fail++;
          $error("FAIL rsp_unexpected: observed result=%0h expected no response", got.r);
        end
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          chk("rsp_result", got.r, want.r);
          chk("rsp_carry", got.c, want.c);
          chk("rsp_opcode", got.op, want.op);
`ifdef ALU_ISSUE_TAG_EN
          chk("rsp_tag", got.tag, want.tag);
`endif
        end
      end
      if (fire) begin
        n_push++;
        exp_q.push_back(cmd_e);
      end
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] sh, input logic [3:0] tg);
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_shamt  = sh;
`ifdef ALU_ISSUE_TAG_EN
    cmd_tag    = tg;
`else
    if (tg != 4'd0) cmd_shamt = sh;
`endif
    cmd_valid  = 1'b1;
  endtask

  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] sh, input logic [3:0] tg);
    int n;
    drive(op, a, b, sh, tg);
    n = 0;
    do begin
      step();
      n++;
    end while (!last_fire && n < 200);
    chk("send_accepted", last_fire, 1'b1);
    cmd_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(4'($urandom_range(0, 15)), {$urandom(), $urandom()}, {$urandom(), $urandom()},
         5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic wait_rsp_valid();
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    chk("rsp_valid_seen", rsp_valid, 1'b1);
  endtask

  initial begin
    logic [3:0]  s_op;
    logic [63:0] s_a;
    logic [63:0] s_b;
    logic [4:0]  s_sh;
    int          rsp_base;
    n_assert   = 0;
    n_fail     = 0;
    n_push     = 0;
    n_rsp      = 0;
    last_fire  = 1'b0;
    rand_ready = 1'b0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_shamt  = '0;
    rsp_ready  = 1'b0;
`ifdef ALU_ISSUE_TAG_EN
    cmd_tag    = '0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_result", rsp_result, 64'd0);
    chk("reset_alu_input1", alu_input1, 64'd0);
    chk("reset_alu_opcode", alu_opcode, 4'd0);
    chk("reset_fifo_count", fifo_count, 3'd0);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    step();

    rsp_ready = 1'b1;
    drive(4'd0, 64'd5, 64'd7, 5'd0, 4'd0);
    step();
    chk("add_push_fire", last_fire, 1'b1);
    cmd_valid = 1'b0;
    chk("add_e1_count", fifo_count, 3'd1);
    chk("add_e1_rsp_valid", rsp_valid, 1'b0);
    step();
    chk("add_e2_count", fifo_count, 3'd0);
    chk("add_e2_rsp_valid", rsp_valid, 1'b0);
    chk("add_e2_alu_input1", alu_input1, 64'd5);
    chk("add_e2_alu_input2", alu_input2, 64'd7);
    step();
    chk("add_e3_rsp_valid", rsp_valid, 1'b1);
    chk("add_e3_rsp_result", rsp_result, 64'd12);
    chk("add_e3_rsp_opcode", rsp_opcode, 4'd0);
    step();
    chk("add_e4_rsp_valid", rsp_valid, 1'b0);
    chk("add_e4_queue", exp_q.size(), 0);

    drive(4'd7, 64'd3, 64'd4, 5'd9, 4'd0);
    step();
    cmd_valid = 1'b0;
    step();
    chk("mul_alu_opcode", alu_opcode, 4'd7);
    chk("mul_alu_input1", alu_input1, 64'd3);
    s_op = alu_opcode; s_a = alu_input1; s_b = alu_input2; s_sh = alu_shiftValue;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mul_exec_rsp_valid", rsp_valid, 1'b0);
      chk("mul_stable", {alu_opcode, alu_input1, alu_input2, alu_shiftValue}, {s_op, s_a, s_b, s_sh});
    end
    step();
    chk("mul_e5_rsp_valid", rsp_valid, 1'b1);
    chk("mul_e5_rsp_result", rsp_result, 64'd12);
    drain();

    rsp_ready = 1'b0;
    rsp_base  = n_rsp;
    for (int i = 0; i < 5; i++) send_rand();
    drive(4'($urandom_range(0, 10)), {$urandom(), $urandom()}, {$urandom(), $urandom()}, 5'd3, 4'd0);
    repeat (3) step();
    chk("full_6th_held", last_fire, 1'b0);
    chk("full_cmd_ready", cmd_ready, 1'b0);
    chk("full_fifo_count", fifo_count, 3'd4);
    chk("full_rsp_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        step();
        n++;
      end while (!last_fire && n < 100);
      chk("full_6th_accepted", last_fire, 1'b1);
    end
    cmd_valid = 1'b0;
    drain();
    chk("full_rsp_total", n_rsp - rsp_base, 6);

    rsp_ready = 1'b0;
    send(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, 4'd0);
    wait_rsp_valid();
    chk("carry_result", rsp_result, 64'd0);
    chk("carry_flag", rsp_carry, 1'b1);
    rsp_ready = 1'b1;
    drain();

    for (int i = 0; i < 2 * DEPTH + 1; i++) send_rand();
    drain();
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) send_rand();
    drain();
    rand_ready = 1'b0;
    rsp_ready  = 1'b1;
    chk("push_rsp_balance", n_rsp, n_push);

    send(4'd7, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 5'd1, 4'd0);
    send(4'd2, 64'hF0, 64'h3C, 5'd0, 4'd0);
    send(4'd3, 64'hF0, 64'h3C, 5'd0, 4'd0);
    chk("rst_pre_count", fifo_count, 3'd2);
    chk("rst_pre_mul", alu_opcode, 4'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_alu_opcode", alu_opcode, 4'd0);
    chk("rst_alu_inputs", {alu_input1, alu_input2, alu_shiftValue}, 133'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_fields", {rsp_result, rsp_carry, rsp_opcode}, 69'd0);
    chk("rst_fifo_count", fifo_count, 3'd0);
    exp_q.delete();
    n_push = n_rsp;
    step();
    rst_n = 1'b1;
    chk("rst_rel_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rel_count", fifo_count, 3'd0);
    repeat (10) step();
    chk("rst_no_stale", rsp_valid, 1'b0);
    chk("rst_no_stale_count", n_rsp, n_push);

`ifdef ALU_ISSUE_TAG_EN
    rsp_ready = 1'b1;
    send(4'd0, 64'd1, 64'd2, 5'd0, 4'd3);
    send(4'd10, 64'hFF, 64'h0F, 5'd0, 4'd9);
    send(4'd1, 64'd100, 64'd1, 5'd0, 4'd12);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
